// File: rtl/minimac3_slotctl.sv
// minimac3_slotctl
// ----------------
// Control/CSR block for the MAC. Owns RX_SLOTS receive buffers, each with its
// own ownership state machine, and provides the TX start/done handshake, a
// saturating RX-drop counter and the RX/TX level interrupts. Every input is
// already synchronous to sys_clk.
//
// Ports:
//   sys_clk    system clock
//   sys_rst_n  asynchronous active-low reset
//   csr_a      CSR address; [13:10] page select, [4:0] register index
//   csr_we     CSR write strobe
//   csr_di     CSR write data
//   csr_do     CSR read data, registered (one cycle latency)
//   irq_rx     RX interrupt (level, registered)
//   irq_tx     TX interrupt (level, registered)
//   rx_ready   per-slot "armed for reception"
//   rx_done    per-slot one-cycle "frame received" pulse
//   rx_count   per-slot byte count, slot i at [i*COUNT_W +: COUNT_W]
//   rx_drop    one-cycle pulse: frame dropped, no slot armed
//   tx_start   one-cycle pulse starting a transmission
//   tx_done    one-cycle pulse: transmission finished
//   tx_count   byte count of the frame to send
//
// Slot FSM:
//   state   | meaning
//   EMPTY   | owned by software, not armed
//   LOADED  | armed, hardware may fill it (rx_ready high)
//   PENDING | frame received, count latched, waiting for software
//
// Register map (index = csr_a[4:0]):
//   0..RX_SLOTS-1    slot state (RW, write 0 = EMPTY, 1 = LOADED)
//   8..8+RX_SLOTS-1  slot byte count (RO)
//   16               tx_count (RW, nonzero write while idle starts TX)
//   17               status: [0] tx_busy, [1] tx_event, [8 +: RX_SLOTS] pending
//                    write bit1 = 1 clears tx_event
//   18               drop counter (16-bit, saturating, any write clears)
//   19               irq enable: [0] rx_en, [1] tx_en

module minimac3_slotctl #(
    parameter logic [3:0] csr_addr = 4'h0,
    parameter int         RX_SLOTS = 4,
    parameter int         COUNT_W  = 11
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,

    input  logic [13:0]                   csr_a,
    input  logic                          csr_we,
    input  logic [31:0]                   csr_di,
    output logic [31:0]                   csr_do,

    output logic                          irq_rx,
    output logic                          irq_tx,

    output logic [RX_SLOTS-1:0]           rx_ready,
    input  logic [RX_SLOTS-1:0]           rx_done,
    input  logic [RX_SLOTS*COUNT_W-1:0]   rx_count,
    input  logic                          rx_drop,

    output logic                          tx_start,
    input  logic                          tx_done,
    output logic [COUNT_W-1:0]            tx_count
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_LOADED  = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    localparam logic [4:0] R_TX_COUNT = 5'd16;
    localparam logic [4:0] R_STATUS   = 5'd17;
    localparam logic [4:0] R_DROP     = 5'd18;
    localparam logic [4:0] R_IRQ_EN   = 5'd19;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         slot_state [RX_SLOTS];
    logic [COUNT_W-1:0] slot_count [RX_SLOTS];

    logic        tx_busy;
    logic        tx_event;
    logic [15:0] drop_cnt;
    logic        rx_en;
    logic        tx_en;

    // ------------------------------------------------------------------
    // CSR decode
    // ------------------------------------------------------------------
    logic                page_sel;
    logic [4:0]          reg_idx;
    logic                wr_sel;
    logic [RX_SLOTS-1:0] slot_wr;
    logic [RX_SLOTS-1:0] pend_mask;
    logic                tx_go;
    logic                event_clr;
    logic                drop_clr;
    logic [31:0]         rd_data;

    // Address bits [9:5] and write data above the widest field are don't-care.
    logic unused_bits;
    assign unused_bits = ^{csr_a[9:5], csr_di[31:COUNT_W]};

    assign page_sel = (csr_a[13:10] == csr_addr);
    assign reg_idx  = csr_a[4:0];
    assign wr_sel   = csr_we & page_sel;

    assign tx_go     = wr_sel && (reg_idx == R_TX_COUNT) &&
                       (csr_di[COUNT_W-1:0] != '0) && !tx_busy;
    assign event_clr = wr_sel && (reg_idx == R_STATUS) && csr_di[1];
    assign drop_clr  = wr_sel && (reg_idx == R_DROP);

    always_comb begin
        slot_wr   = '0;
        pend_mask = '0;
        rx_ready  = '0;
        for (int i = 0; i < RX_SLOTS; i++) begin
            slot_wr[i]   = wr_sel && (reg_idx == 5'(i));
            pend_mask[i] = (slot_state[i] == ST_PENDING);
            rx_ready[i]  = (slot_state[i] == ST_LOADED);
        end
    end

    // ------------------------------------------------------------------
    // Per-slot ownership FSMs
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < RX_SLOTS; i++) begin
                slot_state[i] <= ST_EMPTY;
                slot_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RX_SLOTS; i++) begin
                case (slot_state[i])
                    ST_EMPTY: begin
                        if (slot_wr[i] && csr_di[1:0] == 2'd1)
                            slot_state[i] <= ST_LOADED;
                    end
                    ST_LOADED: begin
                        // A frame landing in the same cycle as a software
                        // write must not be lost, so rx_done takes priority.
                        if (rx_done[i]) begin
                            slot_state[i] <= ST_PENDING;
                            slot_count[i] <= rx_count[i*COUNT_W +: COUNT_W];
                        end else if (slot_wr[i] && csr_di[1:0] == 2'd0) begin
                            slot_state[i] <= ST_EMPTY;
                        end
                    end
                    ST_PENDING: begin
                        if (slot_wr[i] && csr_di[1:0] == 2'd0)
                            slot_state[i] <= ST_EMPTY;
                        else if (slot_wr[i] && csr_di[1:0] == 2'd1)
                            slot_state[i] <= ST_LOADED;
                    end
                    default: slot_state[i] <= ST_EMPTY;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // TX handshake
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_start <= 1'b0;
            tx_count <= '0;
            tx_busy  <= 1'b0;
            tx_event <= 1'b0;
        end else begin
            tx_start <= tx_go;
            if (tx_go) begin
                tx_count <= csr_di[COUNT_W-1:0];
                tx_busy  <= 1'b1;
            end else if (tx_done) begin
                tx_busy  <= 1'b0;
            end
            // A completion must never be lost to a concurrent clear.
            if (tx_done)
                tx_event <= 1'b1;
            else if (event_clr)
                tx_event <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Drop counter and interrupt enables
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= rx_drop ? 16'd1 : 16'd0;
        end else if (rx_drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_en <= 1'b0;
            tx_en <= 1'b0;
        end else if (wr_sel && reg_idx == R_IRQ_EN) begin
            rx_en <= csr_di[0];
            tx_en <= csr_di[1];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            irq_rx <= 1'b0;
            irq_tx <= 1'b0;
        end else begin
            irq_rx <= rx_en & (|pend_mask);
            irq_tx <= tx_en & tx_event;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        if (page_sel) begin
            for (int i = 0; i < RX_SLOTS; i++) begin
                if (reg_idx == 5'(i))
                    rd_data = {30'b0, slot_state[i]};
                if (reg_idx == 5'(8 + i))
                    rd_data = 32'(slot_count[i]);
            end
            case (reg_idx)
                R_TX_COUNT: rd_data = 32'(tx_count);
                R_STATUS:   rd_data = 32'({pend_mask, 6'b0, tx_event, tx_busy});
                R_DROP:     rd_data = {16'b0, drop_cnt};
                R_IRQ_EN:   rd_data = {30'b0, tx_en, rx_en};
                default:    ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            csr_do <= '0;
        else
            csr_do <= rd_data;
    end

endmodule

// File: tb/tb_minimac3_slotctl.sv
module tb_minimac3_slotctl;

    localparam logic [3:0] PAGE = 4'h5;
    localparam int NS = 4;
    localparam int CW = 11;

    logic          sys_clk;
    logic          sys_rst_n;
    logic [13:0]   csr_a;
    logic          csr_we;
    logic [31:0]   csr_di;
    logic [31:0]   csr_do;
    logic          irq_rx;
    logic          irq_tx;
    logic [NS-1:0] rx_ready;
    logic [NS-1:0] rx_done;
    logic [NS*CW-1:0] rx_count;
    logic          rx_drop;
    logic          tx_start;
    logic          tx_done;
    logic [CW-1:0] tx_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    minimac3_slotctl #(.csr_addr(PAGE), .RX_SLOTS(NS), .COUNT_W(CW)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .csr_a    (csr_a),
        .csr_we   (csr_we),
        .csr_di   (csr_di),
        .csr_do   (csr_do),
        .irq_rx   (irq_rx),
        .irq_tx   (irq_tx),
        .rx_ready (rx_ready),
        .rx_done  (rx_done),
        .rx_count (rx_count),
        .rx_drop  (rx_drop),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .tx_count (tx_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] ad(input logic [4:0] r);
        return {PAGE, 5'b0, r};
    endfunction

    // Read: expectation queued when the address is driven, compared when
    // the registered read data appears one edge later.
    task automatic rd_a(input logic [13:0] a, input logic [31:0] exp, input string tag);
        @(negedge sys_clk);
        csr_a  = a;
        csr_we = 1'b0;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge sys_clk);
        chk(tag_q.pop_front(), csr_do, exp_q.pop_front());
    endtask

    task automatic rd(input logic [4:0] r, input logic [31:0] exp, input string tag);
        rd_a(ad(r), exp, tag);
    endtask

    task automatic wr_a(input logic [13:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        wr_a(ad(r), d);
    endtask

    task automatic set_cnt(input int s, input logic [CW-1:0] v);
        rx_count[s*CW +: CW] = v;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        csr_a = '0; csr_we = 1'b0; csr_di = '0;
        rx_done = '0; rx_count = '0; rx_drop = 1'b0; tx_done = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Reset state
        @(negedge sys_clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'h0);
        chk("rst_irq", {30'b0, irq_rx, irq_tx}, 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        for (int r = 0; r < 4; r++) rd(5'(r), 32'h0, "rst_slot");
        for (int r = 16; r < 20; r++) rd(5'(r), 32'h0, "rst_reg");

        // Slot 2 receive path
        wr(2, 1);
        chk("arm2_ready", 32'(rx_ready), 32'h4);
        rd(2, 32'h1, "arm2_state");
        wr(19, 1);
        @(negedge sys_clk);
        rx_done = 4'b0100; set_cnt(2, 11'd64);
        @(negedge sys_clk);
        rx_done = '0; rx_count = '0;
        chk("rx2_ready_fall", 32'(rx_ready), 32'h0);
        rd(2, 32'h2, "rx2_state");
        rd(10, 32'd64, "rx2_count");
        rd(17, 32'h400, "rx2_status");
        chk("rx2_irq_rx", 32'(irq_rx), 32'h1);
        wr(2, 0);
        @(negedge sys_clk);
        chk("rx2_irq_rx_clr", 32'(irq_rx), 32'h0);

        // Ignored writes / ignored rx_done / page and unmapped decode
        wr(0, 2);
        rd(0, 32'h0, "wr2_ignored");
        @(negedge sys_clk);
        rx_done = 4'b0001; set_cnt(0, 11'd5);
        @(negedge sys_clk);
        rx_done = '0; rx_count = '0;
        rd(8, 32'h0, "empty_rx_count");
        rd(0, 32'h0, "empty_rx_state");
        wr_a({4'h2, 10'd0}, 32'h1);
        rd(0, 32'h0, "other_page_wr");
        rd_a({4'h2, 5'b0, 5'd19}, 32'h0, "other_page_rd");
        rd(5, 32'h0, "unmapped_5");
        rd(20, 32'h0, "unmapped_20");

        // Slot 1: rx_done beats a coincident software write
        wr(1, 1);
        @(negedge sys_clk);
        csr_a = ad(1); csr_di = 32'h0; csr_we = 1'b1;
        rx_done = 4'b0010; set_cnt(1, 11'd1514);
        @(negedge sys_clk);
        csr_we = 1'b0; rx_done = '0; rx_count = '0;
        rd(1, 32'h2, "race_state");
        rd(9, 32'd1514, "race_count");
        wr(1, 1);
        rd(1, 32'h1, "rearm_state");
        wr(3, 1);
        chk("arm13_ready", 32'(rx_ready), 32'ha);
        @(negedge sys_clk);
        rx_done = 4'b1010; set_cnt(1, 11'd100); set_cnt(3, 11'd200);
        @(negedge sys_clk);
        rx_done = '0; rx_count = '0;
        rd(17, 32'ha00, "multi_pending");
        rd(9, 32'd100, "multi_count1");
        rd(11, 32'd200, "multi_count3");

        // TX handshake
        wr(19, 3);
        wr(16, 60);
        chk("tx_start_hi", 32'(tx_start), 32'h1);
        chk("tx_count", 32'(tx_count), 32'd60);
        @(negedge sys_clk);
        chk("tx_start_lo", 32'(tx_start), 32'h0);
        rd(17, 32'ha01, "tx_busy");
        wr(16, 100);
        chk("tx_busy_wr_start", 32'(tx_start), 32'h0);
        rd(16, 32'd60, "tx_busy_wr_count");
        @(negedge sys_clk); tx_done = 1'b1;
        @(negedge sys_clk); tx_done = 1'b0;
        rd(17, 32'ha02, "tx_done_status");
        chk("irq_tx_set", 32'(irq_tx), 32'h1);
        wr(17, 2);
        rd(17, 32'ha00, "tx_event_clr");
        chk("irq_tx_clr", 32'(irq_tx), 32'h0);
        wr(16, 0);
        chk("tx_zero_start", 32'(tx_start), 32'h0);
        rd(17, 32'ha00, "tx_zero_status");
        @(negedge sys_clk); tx_done = 1'b1;
        @(negedge sys_clk); tx_done = 1'b0;
        rd(17, 32'ha02, "spurious_done");
        @(negedge sys_clk);
        csr_a = ad(17); csr_di = 32'h2; csr_we = 1'b1; tx_done = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0; tx_done = 1'b0;
        rd(17, 32'ha02, "done_vs_clr");

        // Drop counter
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk); rx_drop = 1'b1;
            @(negedge sys_clk); rx_drop = 1'b0;
        end
        rd(18, 32'd3, "drop_3");
        wr(18, 0);
        rd(18, 32'd0, "drop_clr");
        @(negedge sys_clk); rx_drop = 1'b1;
        repeat (65537) @(negedge sys_clk);
        rx_drop = 1'b0;
        rd(18, 32'hffff, "drop_sat");
        @(negedge sys_clk);
        csr_a = ad(18); csr_di = 32'h0; csr_we = 1'b1; rx_drop = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0; rx_drop = 1'b0;
        rd(18, 32'd1, "drop_clr_vs_inc");

        // Asynchronous reset mid-transmission
        wr(0, 1);
        wr(16, 33);
        @(negedge sys_clk);
        csr_a = ad(17);
        repeat (2) @(negedge sys_clk);
        chk("pre_rst_status", csr_do, 32'ha03);
        chk("pre_rst_ready", 32'(rx_ready), 32'h1);
        chk("pre_rst_irq", {30'b0, irq_rx, irq_tx}, 32'h3);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("arst_csr_do", csr_do, 32'h0);
        chk("arst_ready", 32'(rx_ready), 32'h0);
        chk("arst_irq", {30'b0, irq_rx, irq_tx}, 32'h0);
        chk("arst_tx", {20'b0, tx_count, tx_start}, 32'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk); tx_done = 1'b1;
        @(negedge sys_clk); tx_done = 1'b0;
        rd(17, 32'h2, "post_rst_spurious");
        rd(0, 32'h0, "post_rst_slot0");
        rd(19, 32'h0, "post_rst_irq_en");

        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
